// File: rtl/mem_access_unit.sv
// MEM-stage data-bus controller: turns load/store requests into aligned
// valid/ready bus transactions, stalls the pipeline until completion and
// holds the raw read word for MEM/WB.
// Optional build macro: MEM_ADDR_CHECK_EN enables misalignment detection
// (AdEL/AdES and BadVAddr); without it those outputs are tied to zero.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_in,
    input  logic                  mem_read_flag_in,
    input  logic                  mem_write_flag_in,
    input  logic                  mem_sign_ext_flag_in,
    input  logic [1:0]            mem_size_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [31:0]           mem_write_data_in,
    output logic                  ram_en,
    output logic [3:0]            ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_write_data,
    input  logic                  ram_ready,
    input  logic                  ram_rvalid,
    input  logic [31:0]           ram_read_data,
    output logic [31:0]           read_data_out,
    output logic [3:0]            mem_sel_out,
    output logic                  mem_sign_ext_flag_out,
    output logic                  stall_request,
    output logic                  addr_err_load,
    output logic                  addr_err_store,
    output logic [ADDR_WIDTH-1:0] bad_vaddr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        is_load;
    logic        drop;
    logic [3:0]  sel;
    logic [31:0] store_data;
    logic        misaligned;
    logic        access;
    logic        discard;

    // Little-endian byte-lane select from size and low address bits
    always_comb begin
        sel = 4'b1111;
        case (mem_size_in)
            2'd0:    sel = 4'b0001 << address_in[1:0];
            2'd1:    sel = 4'b0011 << {address_in[1], 1'b0};
            default: sel = 4'b1111;
        endcase
    end

    // Replicate right-aligned store data across all lanes
    always_comb begin
        store_data = mem_write_data_in;
        case (mem_size_in)
            2'd0:    store_data = {4{mem_write_data_in[7:0]}};
            2'd1:    store_data = {2{mem_write_data_in[15:0]}};
            default: store_data = mem_write_data_in;
        endcase
    end

`ifdef MEM_ADDR_CHECK_EN
    // Alignment check: halves need addr[0]==0, words (and reserved size) addr[1:0]==0
    always_comb begin
        misaligned = 1'b0;
        case (mem_size_in)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = address_in[0];
            default: misaligned = |address_in[1:0];
        endcase
    end

    assign addr_err_load  = misaligned & mem_read_flag_in;
    assign addr_err_store = misaligned & mem_write_flag_in;
    assign bad_vaddr      = (addr_err_load | addr_err_store) ? address_in : '0;
`else
    assign misaligned     = 1'b0;
    assign addr_err_load  = 1'b0;
    assign addr_err_store = 1'b0;
    assign bad_vaddr      = '0;
`endif

    assign access                = (mem_read_flag_in | mem_write_flag_in) & ~misaligned & ~flush;
    assign mem_sel_out           = sel;
    assign mem_sign_ext_flag_out = mem_sign_ext_flag_in;
    assign stall_request         = ((state == IDLE) & access) | (state == REQ) | (state == WAIT);
    // A flush seen now or earlier in the transaction suppresses the result
    assign discard               = drop | flush;

    // Bus transaction FSM with registered bus outputs and captured read word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ram_en         <= 1'b0;
            ram_write_en   <= '0;
            ram_addr       <= '0;
            ram_write_data <= '0;
            read_data_out  <= '0;
            is_load        <= 1'b0;
            drop           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        ram_addr       <= {address_in[ADDR_WIDTH-1:2], 2'b00};
                        ram_write_en   <= mem_write_flag_in ? sel : 4'b0000;
                        ram_write_data <= store_data;
                        is_load        <= ~mem_write_flag_in;
                        drop           <= 1'b0;
                        ram_en         <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (ram_ready) begin
                        ram_en <= 1'b0;
                        if (!is_load || ram_rvalid) begin
                            // Store accepted, or load data returned alongside ready
                            if (is_load && !discard) begin
                                read_data_out <= ram_read_data;
                            end
                            state <= discard ? IDLE : DONE;
                            drop  <= 1'b0;
                        end else begin
                            state <= WAIT;
                            drop  <= discard;
                        end
                    end else begin
                        drop <= discard;
                    end
                end
                WAIT: begin
                    if (ram_rvalid) begin
                        if (!discard) begin
                            read_data_out <= ram_read_data;
                        end
                        state <= discard ? IDLE : DONE;
                        drop  <= 1'b0;
                    end else begin
                        drop <= discard;
                    end
                end
                DONE: begin
                    if (flush || !stall_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-bus controller; sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns a load/store request into an aligned bus transaction with a valid/ready handshake.
- Generates the byte-lane select and replicated store data, and flags address errors.
- Stalls the pipeline until the transaction completes, then holds the raw read word for MEM/WB to capture.

Parameters:
ADDR_WIDTH, 32, width of address_in, ram_addr and bad_vaddr.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush (exception/eret)
stall_in  in  1  downstream stage stalled; hold completed result
mem_read_flag_in  in  1  load request
mem_write_flag_in  in  1  store request
mem_sign_ext_flag_in  in  1  load sign-extend (passed through to mem_sign_ext_flag_out)
mem_size_in  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
address_in  in  ADDR_WIDTH  effective virtual address
mem_write_data_in  in  32  store data, right-aligned
ram_en  out  1  bus request valid
ram_write_en  out  4  per-byte write strobes (0 for loads)
ram_addr  out  ADDR_WIDTH  word-aligned address {address_in[31:2],2'b00}
ram_write_data  out  32  replicated store data
ram_ready  in  1  bus accepted request
ram_rvalid  in  1  read data valid
ram_read_data  in  32  read word
read_data_out  out  32  captured read word, held
mem_sel_out  out  4  byte-lane select for WB extraction
mem_sign_ext_flag_out  out  1  pass-through
stall_request  out  1  stall IF..MEM
addr_err_load  out  1  unaligned load (AdEL)
addr_err_store  out  1  unaligned store (AdES)
bad_vaddr  out  ADDR_WIDTH  faulting address (BadVAddr)

Behaviour:
- Byte select, little-endian:
  - byte: 4'b0001<<address_in[1:0]
  - half: 4'b0011<<{address_in[1],1'b0}
  - word: 4'b1111
  - mem_sel_out is combinational from the inputs.
- Store data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - Raises addr_err_load or addr_err_store combinationally; bad_vaddr=address_in.
  - No bus request is issued and stall_request=0.
- access = (read|write) & !misaligned & !flush.
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE:
  - If access: latch ram_addr, ram_write_en (sel if write, else 0), ram_write_data and a read flag; ram_en<=1; go to REQ.
- REQ:
  - ram_en held at 1 with address/data stable until ram_ready.
  - On ram_ready: ram_en<=0; a store goes to DONE, a load goes to WAIT.
  - If ram_ready and ram_rvalid arrive in the same cycle on a load: capture the data and go directly to DONE.
- WAIT: on ram_rvalid, read_data_out<=ram_read_data; go to DONE.
- DONE: if !stall_in, go to IDLE; otherwise stay, holding read_data_out.
- stall_request = (IDLE & access) | REQ | WAIT. It is deasserted in DONE.
- Minimum latency:
  - Store: request cycle + 1 (ready in REQ's first cycle), so stall is 2 cycles.
  - Load with rvalid one cycle after ready: stall is 3 cycles.
- Flush during REQ/WAIT:
  - Set a drop flag; the bus transaction still completes (no abort on the bus).
  - stall_request stays 1 until completion.
  - Data is not captured; return directly to IDLE, skipping DONE; clear the drop flag.
- Flush in IDLE or DONE: no new request; DONE goes to IDLE.
- A new request is accepted only in IDLE; no back-to-back issue in DONE.
- Reset (asynchronous, any state), all outputs and registers zero:
  - state=IDLE, ram_en=0, ram_write_en=0, ram_addr=0, ram_write_data=0, read_data_out=0, drop flag=0.
  - Combinational outputs follow their inputs.
- A bus transaction in flight at reset is abandoned; the bus is reset by the same rst.

Optional Feature:
MEM_ADDR_CHECK_EN:
- Defined: misalignment detection as above; addr_err_load, addr_err_store and bad_vaddr are active.
- Undefined: misalignment is never flagged.
  - addr_err_* are tied 0 and bad_vaddr is tied 0.
  - The access proceeds with address_in[1:0] used only for mem_sel_out; the bus address is still word-aligned.

Test Plan:
- Word load at 0x8000_0010, ready on cycle 1, rvalid with 0xDEADBEEF on cycle 2 -> ram_addr=0x8000_0010, ram_write_en=0, stall_request high 3 cycles, read_data_out=0xDEADBEEF, mem_sel_out=4'b1111.
- Byte store 0x000000A5 at 0x...03 -> ram_write_en=4'b1000, ram_write_data=0xA5A5A5A5, ram_addr=0x...00, FSM goes to DONE after ready.
- Half load at 0x...01 with MEM_ADDR_CHECK_EN defined -> addr_err_load=1, bad_vaddr=0x...01, ram_en never asserted, stall_request=0. Same case with the macro undefined -> access issued, mem_sel_out=4'b0011.
- Load, flush asserted while in WAIT, rvalid 2 cycles later with 0x12345678 -> stall held until rvalid, read_data_out unchanged, state IDLE next cycle.
- Load completes with stall_in=1 for 3 cycles -> FSM stays in DONE, read_data_out stable, no new ram_en; IDLE after stall_in falls.
- rst pulsed asynchronously while in REQ -> ram_en=0 and state IDLE immediately, before the next edge; all registered outputs 0.
